// File: rtl/fpu_issue_ctl.sv
// FPU issue stage: 2-entry op FIFO, one-at-a-time fixed-latency issue, writeback and a
// per-register pending scoreboard that decode uses to stall FP register hazards.
//
// state | meaning
// IDLE  | no op executing; loads the FIFO head when one is queued
// EXEC  | op on the datapath; down-counter cnt hits 0 in the last cycle
module fpu_issue_ctl #(
  parameter int unsigned LAT_ADD = 3,
  parameter int unsigned LAT_MUL = 4,
  parameter int unsigned LAT_FMA = 6,
  parameter int unsigned LAT_MV  = 1
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        dec_fpu_valid,
  input  logic [3:0]  dec_fpu_op,
  input  logic        dec_fpu_op_mod,
  input  logic [2:0]  dec_fpu_rnd_mode,
  input  logic [4:0]  dec_fpu_rs1,
  input  logic [4:0]  dec_fpu_rs2,
  input  logic [4:0]  dec_fpu_rs3,
  input  logic [4:0]  dec_fpu_rd,
  input  logic [31:0] dec_fpu_a,
  input  logic [31:0] dec_fpu_b,
  input  logic [31:0] dec_fpu_c,
  input  logic        dec_fpu_flush,
  output logic        fpu_dec_ready,
  output logic        fpu_dec_raw_stall,
  output logic        fpu_dp_start,
  output logic [3:0]  fpu_dp_op,
  output logic        fpu_dp_op_mod,
  output logic [2:0]  fpu_dp_rnd_mode,
  output logic [31:0] fpu_dp_a,
  output logic [31:0] fpu_dp_b,
  output logic [31:0] fpu_dp_c,
  input  logic [31:0] dp_fpu_result,
  input  logic [4:0]  dp_fpu_flags,
  output logic        fpu_wb_valid,
  output logic [4:0]  fpu_wb_rd,
  output logic [31:0] fpu_wb_data,
  output logic [4:0]  fpu_wb_flags,
  output logic        fpu_busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        op_mod;
    logic [2:0]  rnd_mode;
    logic [4:0]  rd;
    logic        unl;
    logic [7:0]  cnt_init;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } entry_t;

  entry_t      fifo_q [2];
  entry_t      push_e;
  entry_t      head_e;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [31:0] pend;
  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  cur_rd;
  logic        cur_unl;
  logic        accept;
  logic        pop;
  logic        last_exec;

  // Counter load value is latency minus one so that cnt == 0 marks the last EXEC cycle.
  function automatic logic [7:0] lat_m1(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: lat_m1 = 8'(LAT_ADD - 1);
      4'd2:       lat_m1 = 8'(LAT_MUL - 1);
      4'd3, 4'd4: lat_m1 = 8'(LAT_FMA - 1);
      default:    lat_m1 = 8'(LAT_MV - 1);
    endcase
  endfunction

  assign fpu_dec_raw_stall = pend[dec_fpu_rs1] | pend[dec_fpu_rs2] |
                             pend[dec_fpu_rs3] | pend[dec_fpu_rd];
  assign fpu_dec_ready = (count != 2'd2) & ~fpu_dec_raw_stall & ~dec_fpu_flush;
  assign accept        = dec_fpu_valid & fpu_dec_ready;
  assign head_e        = fifo_q[rd_ptr];
  assign last_exec     = (state == EXEC) && (cnt == 8'd0);
  assign pop           = ~dec_fpu_flush && (count != 2'd0) && ((state == IDLE) || last_exec);
  assign fpu_busy      = (count != 2'd0) || (state == EXEC) || fpu_wb_valid;

  always_comb begin
    push_e          = '0;
    push_e.op       = dec_fpu_op;
    push_e.op_mod   = dec_fpu_op_mod;
    push_e.rnd_mode = dec_fpu_rnd_mode;
    push_e.rd       = dec_fpu_rd;
    push_e.unl      = (dec_fpu_op > 4'd5);
    push_e.cnt_init = lat_m1(dec_fpu_op);
    push_e.a        = dec_fpu_a;
    push_e.b        = dec_fpu_b;
    push_e.c        = dec_fpu_c;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (accept) begin
      fifo_q[wr_ptr] <= push_e;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      cnt             <= '0;
      count           <= '0;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      pend            <= '0;
      cur_rd          <= '0;
      cur_unl         <= 1'b0;
      fpu_dp_start    <= 1'b0;
      fpu_dp_op       <= '0;
      fpu_dp_op_mod   <= 1'b0;
      fpu_dp_rnd_mode <= '0;
      fpu_dp_a        <= '0;
      fpu_dp_b        <= '0;
      fpu_dp_c        <= '0;
      fpu_wb_valid    <= 1'b0;
      fpu_wb_rd       <= '0;
      fpu_wb_data     <= '0;
      fpu_wb_flags    <= '0;
    end else begin
      fpu_dp_start <= 1'b0;
      fpu_wb_valid <= 1'b0;
      if (fpu_wb_valid) pend[fpu_wb_rd] <= 1'b0;
      if (accept) begin
        wr_ptr          <= ~wr_ptr;
        pend[dec_fpu_rd] <= 1'b1;
      end
      count <= count + {1'b0, accept} - {1'b0, pop};
      if (dec_fpu_flush) begin
        // A completing op and every queued op are dropped; a wb pulse already out finishes.
        state  <= IDLE;
        cnt    <= '0;
        count  <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pend   <= '0;
      end else begin
        if (pop) begin
          state           <= EXEC;
          cnt             <= head_e.cnt_init;
          rd_ptr          <= ~rd_ptr;
          cur_rd          <= head_e.rd;
          cur_unl         <= head_e.unl;
          fpu_dp_start    <= 1'b1;
          fpu_dp_op       <= head_e.op;
          fpu_dp_op_mod   <= head_e.op_mod;
          fpu_dp_rnd_mode <= head_e.rnd_mode;
          fpu_dp_a        <= head_e.a;
          fpu_dp_b        <= head_e.b;
          fpu_dp_c        <= head_e.c;
        end else if (last_exec) begin
          state <= IDLE;
        end else if (state == EXEC) begin
          cnt <= cnt - 8'd1;
        end
        if (last_exec) begin
          fpu_wb_valid <= 1'b1;
          fpu_wb_rd    <= cur_rd;
          fpu_wb_data  <= cur_unl ? 32'd0 : dp_fpu_result;
          fpu_wb_flags <= cur_unl ? 5'b10000 : dp_fpu_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// Bench for fpu_issue_ctl: table of single-op vectors, directed multi-cycle sequences,
// and random traffic against a transaction-timing reference model.
module tb_fpu_issue_ctl;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        dec_fpu_valid;
  logic [3:0]  dec_fpu_op;
  logic        dec_fpu_op_mod;
  logic [2:0]  dec_fpu_rnd_mode;
  logic [4:0]  dec_fpu_rs1, dec_fpu_rs2, dec_fpu_rs3, dec_fpu_rd;
  logic [31:0] dec_fpu_a, dec_fpu_b, dec_fpu_c;
  logic        dec_fpu_flush;
  logic        fpu_dec_ready, fpu_dec_raw_stall, fpu_dp_start;
  logic [3:0]  fpu_dp_op;
  logic        fpu_dp_op_mod;
  logic [2:0]  fpu_dp_rnd_mode;
  logic [31:0] fpu_dp_a, fpu_dp_b, fpu_dp_c;
  logic [31:0] dp_fpu_result = '0;
  logic [4:0]  dp_fpu_flags = '0;
  logic        fpu_wb_valid;
  logic [4:0]  fpu_wb_rd;
  logic [31:0] fpu_wb_data;
  logic [4:0]  fpu_wb_flags;
  logic        fpu_busy;

  fpu_issue_ctl #(.LAT_ADD(3), .LAT_MUL(4), .LAT_FMA(6), .LAT_MV(1)) dut (
    .clk(clk), .rst_l(rst_l),
    .dec_fpu_valid(dec_fpu_valid), .dec_fpu_op(dec_fpu_op), .dec_fpu_op_mod(dec_fpu_op_mod),
    .dec_fpu_rnd_mode(dec_fpu_rnd_mode), .dec_fpu_rs1(dec_fpu_rs1), .dec_fpu_rs2(dec_fpu_rs2),
    .dec_fpu_rs3(dec_fpu_rs3), .dec_fpu_rd(dec_fpu_rd), .dec_fpu_a(dec_fpu_a),
    .dec_fpu_b(dec_fpu_b), .dec_fpu_c(dec_fpu_c), .dec_fpu_flush(dec_fpu_flush),
    .fpu_dec_ready(fpu_dec_ready), .fpu_dec_raw_stall(fpu_dec_raw_stall),
    .fpu_dp_start(fpu_dp_start), .fpu_dp_op(fpu_dp_op), .fpu_dp_op_mod(fpu_dp_op_mod),
    .fpu_dp_rnd_mode(fpu_dp_rnd_mode), .fpu_dp_a(fpu_dp_a), .fpu_dp_b(fpu_dp_b),
    .fpu_dp_c(fpu_dp_c), .dp_fpu_result(dp_fpu_result), .dp_fpu_flags(dp_fpu_flags),
    .fpu_wb_valid(fpu_wb_valid), .fpu_wb_rd(fpu_wb_rd), .fpu_wb_data(fpu_wb_data),
    .fpu_wb_flags(fpu_wb_flags), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] a, b, c;
    logic [31:0] res;
    logic [4:0]  flg;
    int          exp_wb;
    logic [31:0] exp_data;
    logic [4:0]  exp_flags;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic        op_mod;
    logic [2:0]  rnd;
    logic [4:0]  rd;
    logic [31:0] a, b, c;
    int          acc, s, wb;
  } mop_t;

  mop_t mq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    dec_fpu_valid = 0; dec_fpu_op = 0; dec_fpu_op_mod = 0; dec_fpu_rnd_mode = 0;
    dec_fpu_rs1 = 0; dec_fpu_rs2 = 0; dec_fpu_rs3 = 0; dec_fpu_rd = 0;
    dec_fpu_a = 0; dec_fpu_b = 0; dec_fpu_c = 0; dec_fpu_flush = 0;
  endtask

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return 3;
      4'd2:       return 4;
      4'd3, 4'd4: return 6;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] hres(input int t);
    return (32'(t) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [4:0] hflg(input int t);
    return 5'(t * 7 + 3);
  endfunction

  task automatic run_vec(input vec_t v);
    int wb_c, st_c;
    logic [31:0] st_a;
    logic [2:0]  st_rnd;
    wb_c = -1; st_c = -1; st_a = 0; st_rnd = 0;
    idle_inputs();
    dec_fpu_op = v.op; dec_fpu_rd = v.rd; dec_fpu_a = v.a; dec_fpu_b = v.b; dec_fpu_c = v.c;
    dec_fpu_op_mod = 1; dec_fpu_rnd_mode = 3'd2;
    dp_fpu_result = v.res; dp_fpu_flags = v.flg;
    dec_fpu_valid = 1;
    #1 chk("vec_ready", fpu_dec_ready, 1);
    tick();
    dec_fpu_valid = 0;
    dec_fpu_rs1 = v.rd; dec_fpu_rs2 = v.rd; dec_fpu_rs3 = v.rd;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (c <= v.exp_wb + 1) chk("vec_stall", fpu_dec_raw_stall, (c <= v.exp_wb));
      if (fpu_dp_start && st_c < 0) begin
        st_c = c; st_a = fpu_dp_a; st_rnd = fpu_dp_rnd_mode;
      end
      if (fpu_wb_valid && wb_c < 0) begin
        wb_c = c;
        chk("vec_wb_rd", fpu_wb_rd, v.rd);
        chk("vec_wb_data", fpu_wb_data, v.exp_data);
        chk("vec_wb_flags", fpu_wb_flags, v.exp_flags);
      end
      tick();
    end
    chk("vec_start_cyc", st_c, 2);
    chk("vec_dp_a", st_a, v.a);
    chk("vec_dp_rnd", st_rnd, 3'd2);
    chk("vec_wb_cyc", wb_c, v.exp_wb);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   k, wb3, wb4, last_wb;

    vecs[0] = '{4'd0,  5'd5,  32'h3f800000, 32'h40000000, 32'h0,        32'h40400000, 5'h00, 5, 32'h40400000, 5'h00};
    vecs[1] = '{4'd1,  5'd6,  32'h3f800000, 32'h40000000, 32'h0,        32'hbf800000, 5'h01, 5, 32'hbf800000, 5'h01};
    vecs[2] = '{4'd2,  5'd7,  32'h40000000, 32'h40400000, 32'h0,        32'h40c00000, 5'h00, 6, 32'h40c00000, 5'h00};
    vecs[3] = '{4'd3,  5'd8,  32'h40000000, 32'h40400000, 32'h3f800000, 32'h40e00000, 5'h00, 8, 32'h40e00000, 5'h00};
    vecs[4] = '{4'd4,  5'd9,  32'h40000000, 32'h40400000, 32'h3f800000, 32'hc0e00000, 5'h04, 8, 32'hc0e00000, 5'h04};
    vecs[5] = '{4'd5,  5'd10, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 5'h00, 3, 32'h12345678, 5'h00};
    vecs[6] = '{4'd6,  5'd11, 32'h11111111, 32'h22222222, 32'h0,        32'hdeadbeef, 5'h1f, 3, 32'h0,        5'h10};
    vecs[7] = '{4'd15, 5'd12, 32'h33333333, 32'h44444444, 32'h0,        32'hcafef00d, 5'h03, 3, 32'h0,        5'h10};

    idle_inputs();
    rst_l = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", fpu_dec_ready, 1);
    chk("rst_stall", fpu_dec_raw_stall, 0);
    chk("rst_dp_start", fpu_dp_start, 0);
    chk("rst_wb_valid", fpu_wb_valid, 0);
    chk("rst_busy", fpu_busy, 0);
    chk("rst_wb_data", fpu_wb_data, 0);
    chk("rst_dp_a", fpu_dp_a, 0);
    @(negedge clk) rst_l = 1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset while a MUL is executing
    idle_inputs();
    dec_fpu_op = 4'd2; dec_fpu_rd = 5'd9; dec_fpu_a = 32'hAAAA5555; dec_fpu_valid = 1;
    tick();
    dec_fpu_valid = 0;
    tick(); tick();
    rst_l = 0;
    dec_fpu_rs1 = 5'd9;
    #1;
    chk("mrst_wb_valid", fpu_wb_valid, 0);
    chk("mrst_dp_start", fpu_dp_start, 0);
    chk("mrst_busy", fpu_busy, 0);
    chk("mrst_dp_a", fpu_dp_a, 0);
    chk("mrst_dp_op", fpu_dp_op, 0);
    chk("mrst_stall", fpu_dec_raw_stall, 0);
    chk("mrst_ready", fpu_dec_ready, 1);
    @(negedge clk) rst_l = 1;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      chk("mrst_no_wb", fpu_wb_valid, 0);
      chk("mrst_no_start", fpu_dp_start, 0);
    end

    // three MV ops on consecutive cycles
    idle_inputs();
    dec_fpu_op = 4'd5; dec_fpu_valid = 1;
    for (int c = 0; c < 3; c++) begin
      dec_fpu_rd = 5'(c + 1);
      #1 chk("mv_ready", fpu_dec_ready, 1);
      tick();
    end
    dec_fpu_valid = 0;
    for (int c = 3; c <= 6; c++) begin
      #1;
      chk("mv_wb_valid", fpu_wb_valid, (c <= 5));
      if (c <= 5) chk("mv_wb_rd", fpu_wb_rd, c - 2);
      tick();
    end

    // FIFO fills to two entries behind a MUL
    idle_inputs();
    dec_fpu_valid = 1;
    dec_fpu_op = 4'd2; dec_fpu_rd = 5'd10;
    #1 chk("full_ready0", fpu_dec_ready, 1);
    tick();
    dec_fpu_op = 4'd0; dec_fpu_rd = 5'd11;
    #1 chk("full_ready1", fpu_dec_ready, 1);
    tick();
    dec_fpu_rd = 5'd12;
    #1 chk("full_ready2", fpu_dec_ready, 1);
    tick();
    dec_fpu_rd = 5'd13;
    #1 chk("full_ready3", fpu_dec_ready, 0);
    dec_fpu_valid = 0;
    k = 0;
    do begin
      tick();
      #1;
      k++;
    end while (fpu_busy && k < 40);
    chk("full_drain", fpu_busy, 0);
    tick();

    // RAW hazard: ADD reads the FMADD destination
    idle_inputs();
    dec_fpu_op = 4'd3; dec_fpu_rd = 5'd3; dec_fpu_valid = 1;
    #1 chk("haz_ready0", fpu_dec_ready, 1);
    tick();
    dec_fpu_op = 4'd0; dec_fpu_rs1 = 5'd3; dec_fpu_rd = 5'd4;
    wb3 = -1; wb4 = -1;
    for (int c = 1; c <= 18; c++) begin
      #1;
      if (c <= 9) begin
        chk("haz_stall", fpu_dec_raw_stall, (c <= 8));
        chk("haz_ready", fpu_dec_ready, (c > 8));
      end
      if (fpu_wb_valid && fpu_wb_rd == 5'd3 && wb3 < 0) wb3 = c;
      if (fpu_wb_valid && fpu_wb_rd == 5'd4 && wb4 < 0) wb4 = c;
      tick();
      if (c == 9) dec_fpu_valid = 0;
    end
    chk("haz_wb3_cyc", wb3, 8);
    chk("haz_wb4_cyc", wb4, 14);

    // flush on the last EXEC cycle of a MUL with an ADD queued
    idle_inputs();
    dec_fpu_op = 4'd2; dec_fpu_rd = 5'd6; dec_fpu_valid = 1;
    #1 chk("fl_ready0", fpu_dec_ready, 1);
    tick();
    dec_fpu_op = 4'd0; dec_fpu_rd = 5'd7;
    #1 chk("fl_ready1", fpu_dec_ready, 1);
    tick();
    dec_fpu_valid = 0;
    #1;
    chk("fl_dp_start", fpu_dp_start, 1);
    chk("fl_dp_op", fpu_dp_op, 2);
    tick(); tick(); tick();
    dec_fpu_flush = 1; dec_fpu_valid = 1; dec_fpu_rd = 5'd20;
    #1;
    chk("fl_ready_flush", fpu_dec_ready, 0);
    chk("fl_busy_flush", fpu_busy, 1);
    tick();
    dec_fpu_flush = 0; dec_fpu_valid = 0;
    dec_fpu_rd = 5'd20; dec_fpu_rs1 = 5'd6; dec_fpu_rs2 = 5'd7;
    #1;
    chk("fl_wb_valid", fpu_wb_valid, 0);
    chk("fl_busy", fpu_busy, 0);
    chk("fl_ready", fpu_dec_ready, 1);
    chk("fl_stall", fpu_dec_raw_stall, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      chk("fl_no_wb", fpu_wb_valid, 0);
      chk("fl_no_start", fpu_dp_start, 0);
    end
    tick();

    // random traffic against the transaction-timing model
    last_wb = 0;
    for (int i = 0; i < 450; i++) begin
      int   e_cnt, s_idx, w_idx;
      bit   e_stall, e_exec, e_ready;
      mop_t m;
      idle_inputs();
      dp_fpu_result = hres(cyc);
      dp_fpu_flags  = hflg(cyc);
      if (i < 400) begin
        dec_fpu_valid = ($urandom_range(0, 2) != 0);
        dec_fpu_op = 4'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) dec_fpu_op = 4'hF;
        dec_fpu_op_mod = 1'($urandom);
        dec_fpu_rnd_mode = 3'($urandom);
        dec_fpu_rs1 = 5'($urandom_range(0, 7));
        dec_fpu_rs2 = 5'($urandom_range(0, 7));
        dec_fpu_rs3 = 5'($urandom_range(0, 7));
        dec_fpu_rd = 5'($urandom_range(0, 7));
        dec_fpu_a = $urandom; dec_fpu_b = $urandom; dec_fpu_c = $urandom;
      end
      while (mq.size() > 0 && mq[0].wb < cyc) void'(mq.pop_front());
      e_cnt = 0; e_stall = 0; e_exec = 0; s_idx = -1; w_idx = -1;
      for (int j = 0; j < mq.size(); j++) begin
        if (mq[j].acc + 1 <= cyc && cyc <= mq[j].s - 1) e_cnt++;
        if (mq[j].acc + 1 <= cyc && cyc <= mq[j].wb &&
            (mq[j].rd == dec_fpu_rs1 || mq[j].rd == dec_fpu_rs2 ||
             mq[j].rd == dec_fpu_rs3 || mq[j].rd == dec_fpu_rd)) e_stall = 1;
        if (mq[j].s == cyc) s_idx = j;
        if (mq[j].wb == cyc) w_idx = j;
        if (mq[j].s <= cyc && cyc < mq[j].wb) e_exec = 1;
      end
      e_ready = (e_cnt < 2) && !e_stall;
      #1;
      chk("rnd_stall", fpu_dec_raw_stall, e_stall);
      chk("rnd_ready", fpu_dec_ready, e_ready);
      chk("rnd_busy", fpu_busy, (e_cnt > 0) || e_exec || (w_idx >= 0));
      chk("rnd_dp_start", fpu_dp_start, (s_idx >= 0));
      if (s_idx >= 0) begin
        chk("rnd_dp_op", fpu_dp_op, mq[s_idx].op);
        chk("rnd_dp_mod", fpu_dp_op_mod, mq[s_idx].op_mod);
        chk("rnd_dp_rnd", fpu_dp_rnd_mode, mq[s_idx].rnd);
        chk("rnd_dp_a", fpu_dp_a, mq[s_idx].a);
        chk("rnd_dp_b", fpu_dp_b, mq[s_idx].b);
        chk("rnd_dp_c", fpu_dp_c, mq[s_idx].c);
      end
      chk("rnd_wb_valid", fpu_wb_valid, (w_idx >= 0));
      if (w_idx >= 0) begin
        chk("rnd_wb_rd", fpu_wb_rd, mq[w_idx].rd);
        chk("rnd_wb_data", fpu_wb_data, (mq[w_idx].op > 4'd5) ? 32'd0 : hres(cyc - 1));
        chk("rnd_wb_flags", fpu_wb_flags, (mq[w_idx].op > 4'd5) ? 5'h10 : hflg(cyc - 1));
      end
      if (dec_fpu_valid && e_ready) begin
        m.op = dec_fpu_op; m.op_mod = dec_fpu_op_mod; m.rnd = dec_fpu_rnd_mode;
        m.rd = dec_fpu_rd; m.a = dec_fpu_a; m.b = dec_fpu_b; m.c = dec_fpu_c;
        m.acc = cyc;
        m.s = (cyc + 2 > last_wb) ? cyc + 2 : last_wb;
        m.wb = m.s + lat_of(dec_fpu_op);
        last_wb = m.wb;
        mq.push_back(m);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
